dijkstra_sssp_engine: RTL
=========================

// Module: dijkstra_sssp_engine
// PURPOSE
//  Parametrised single-source shortest-path engine for undirected, non-negatively weighted graphs.
//  Edges arrive as a valid/ready stream, not a fixed-width bus; the source node is selectable.
//  The block runs Dijkstra with a linear min-scan and streams one distance per node back out.
//  It sits between the graph loader and the result consumer in the graph-processing datapath.
// PARAMETERS
//  NODE_W  4   node index width; capacity N = 2**NODE_W nodes
//  WT_W    4   edge weight width (unsigned)
//  DIST_W  16  distance width; all-ones (INF) = unreachable
// PORTS
//  clk         in   1                clock, rising edge
//  reset       in   1                asynchronous, active-low reset
//  start       in   1                begins a job when sampled in IDLE; ignored otherwise
//  num_nodes   in   NODE_W+1         node count n (1..N), sampled with start
//  src         in   NODE_W           source node, sampled with start
//  edge_valid  in   1                edge beat valid
//  edge_ready  out  1                engine accepts an edge beat (LOAD only)
//  edge_data   in   2*NODE_W+WT_W    [NODE_W-1:0] node a; [2*NODE_W-1:NODE_W] node b; top WT_W bits = weight
//  edge_last   in   1                final edge of the job, qualified by the handshake
//  dist_valid  out  1                distance beat valid
//  dist_ready  in   1                consumer accepts the distance beat
//  dist_node   out  NODE_W           node index of the current beat
//  dist_value  out  DIST_W           shortest distance from src, or INF
//  dist_last   out  1                beat for node n-1
//  busy        out  1                high from the cycle after start until the job ends
//  done        out  1                1-cycle pulse after the final distance handshake
//  error       out  1                sticky; cleared by the next accepted start
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, adjacency, dist and visited storage cleared. Reset has priority in any state.
//  Storage: N x N weight matrix with per-entry valid bits; dist[N] at DIST_W bits; visited[N].
//  IDLE: on start, latch n and src and clear error.
//   If n==0, n>N or src>=n: set error, pulse done, stay IDLE, produce no beats.
//   Otherwise go to CLEAR.
//  CLEAR (1 cycle): invalidate all adjacency entries, set dist[*]=INF, dist[src]=0, visited=0; go to LOAD.
//  LOAD: edge_ready=1. Each handshake writes adj[a][b] and adj[b][a].
//   A duplicate edge keeps the minimum weight.
//   A self-loop (a==b) is dropped without error.
//   If a>=n or b>=n: the edge is dropped and error is set.
//   A handshake with edge_last=1 goes to SELECT. A job with zero edges still sends one beat with edge_last; that beat is processed as an edge.
//  SELECT: one node per cycle for i=0..N-1. Track the unvisited node with i<n and the smallest dist; ties go to the lowest index.
//   After the scan: if no candidate or min==INF, go to OUTPUT.
//   Otherwise u=min, visited[u]=1, go to RELAX.
//  RELAX: one node per cycle for v=0..N-1. If adj[u][v] is valid, visited[v]==0 and dist[u]+w < dist[v], write dist[v]=dist[u]+w.
//   The sum is computed at DIST_W+1 bits; a sum >= INF never updates.
//   After v=N-1, go to SELECT.
//  OUTPUT: beats for i=0..n-1 in ascending order; dist_valid=1 while in OUTPUT.
//   node, value and last hold stable while dist_valid && !dist_ready.
//   dist_last=1 on i=n-1. The handshake of that beat returns to IDLE and pulses done the next cycle.
//  Compute latency: at most 2N cycles per selected node, plus N for the final empty scan.
//  busy=1 in CLEAR, LOAD, SELECT, RELAX and OUTPUT.
//  Weight-0 edges are legal. Dist values are unsigned; no wrap is possible due to saturation at INF.
// TESTING
//  1. Triangle: n=3, src=0, edges (0,1,4),(1,2,3),(0,2,9) -> beats 0,4,7; dist_last on node 2; done pulses once.
//  2. Unreachable: n=4, src=0, single edge (0,1,2) -> beats 0,2,FFFF,FFFF; error=0.
//  3. Duplicate edges (0,1,9),(1,0,3) plus self-loop (1,1,1), n=2 -> dist[1]=3.
//  4. src=3, n=4, chain 0-1-2-3 with weight 1 each; dist_ready toggles every cycle -> 3,2,1,0; beats stable while stalled.
//  5. Bad input: edge (0,5,1) with n=4 -> edge dropped, error=1 at done.
//     start with src=4, n=4 -> error=1, done pulse, no beats, busy stays 0.
//  6. Reset asserted in RELAX -> all outputs 0 immediately; a start pulse during busy is ignored; the next job after reset matches test 1.

Source files
------------

// File: rtl/dijkstra_sssp_engine.sv
// Single-source shortest-path engine for undirected, non-negatively weighted graphs.
// Edges stream in over a valid/ready port. Dijkstra runs with a linear min-scan
// (SELECT) and a per-neighbour relaxation sweep (RELAX). One distance beat per
// node is then streamed out in ascending node order.
module dijkstra_sssp_engine #(
    parameter int NODE_W = 4,
    parameter int WT_W   = 4,
    parameter int DIST_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NODE_W:0]            num_nodes,
    input  logic [NODE_W-1:0]          src,
    input  logic                       edge_valid,
    output logic                       edge_ready,
    input  logic [2*NODE_W+WT_W-1:0]   edge_data,
    input  logic                       edge_last,
    output logic                       dist_valid,
    input  logic                       dist_ready,
    output logic [NODE_W-1:0]          dist_node,
    output logic [DIST_W-1:0]          dist_value,
    output logic                       dist_last,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int                N_C        = 1 << NODE_W;
    localparam logic [NODE_W:0]   NMAX_C     = {1'b1, {NODE_W{1'b0}}};
    localparam logic [NODE_W:0]   NCNT_ONE_C = {{NODE_W{1'b0}}, 1'b1};
    localparam logic [NODE_W:0]   NCNT_ZERO_C = {(NODE_W+1){1'b0}};
    localparam logic [NODE_W-1:0] IDX_ONE_C  = {{(NODE_W-1){1'b0}}, 1'b1};
    localparam logic [NODE_W-1:0] IDX_ZERO_C = {NODE_W{1'b0}};
    localparam logic [NODE_W-1:0] IDX_LAST_C = {NODE_W{1'b1}};
    localparam logic [DIST_W-1:0] INF_C      = {DIST_W{1'b1}};
    localparam logic [DIST_W-1:0] DZERO_C    = {DIST_W{1'b0}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_SELECT = 3'd3;
    localparam logic [2:0] S_RELAX  = 3'd4;
    localparam logic [2:0] S_OUTPUT = 3'd5;

    // Control state
    logic [2:0]        state_r;
    logic [NODE_W:0]   n_r;
    logic [NODE_W-1:0] src_r;
    logic [NODE_W-1:0] idx_r;        // scan / relax / output index, shared by phase
    logic [NODE_W-1:0] u_r;          // node currently being relaxed
    logic [NODE_W-1:0] best_node_r;
    logic [DIST_W-1:0] best_dist_r;
    logic              found_r;

    // Graph and solution storage
    logic [N_C-1:0]    adj_vld_r [N_C];
    logic [WT_W-1:0]   adj_wt_r  [N_C][N_C];
    logic [DIST_W-1:0] dist_r    [N_C];
    logic [N_C-1:0]    visited_r;

    // Registered outputs
    logic              edge_ready_r;
    logic              dist_valid_r;
    logic [NODE_W-1:0] dist_node_r;
    logic [DIST_W-1:0] dist_value_r;
    logic              dist_last_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;

    // Decode
    logic [NODE_W-1:0] edge_a_s;
    logic [NODE_W-1:0] edge_b_s;
    logic [WT_W-1:0]   edge_w_s;
    logic              edge_hs_s;
    logic              edge_bad_s;
    logic              edge_wr_s;
    logic              start_bad_s;
    logic              sel_take_s;
    logic              sel_found_s;
    logic [NODE_W-1:0] sel_node_s;
    logic [DIST_W-1:0] sel_dist_s;
    logic              sel_commit_s;
    logic              scan_end_s;
    logic [DIST_W:0]   relax_sum_s;
    logic              relax_upd_s;
    logic              out_hs_s;
    logic [NODE_W-1:0] idx_next_s;

    assign edge_ready = edge_ready_r;
    assign dist_valid = dist_valid_r;
    assign dist_node  = dist_node_r;
    assign dist_value = dist_value_r;
    assign dist_last  = dist_last_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;

    // Edge decode, running-minimum candidate, relaxation sum and handshakes
    always_comb begin
        edge_a_s    = edge_data[NODE_W-1:0];
        edge_b_s    = edge_data[2*NODE_W-1:NODE_W];
        edge_w_s    = edge_data[2*NODE_W+WT_W-1:2*NODE_W];
        edge_hs_s   = edge_ready_r & edge_valid;
        edge_bad_s  = ({1'b0, edge_a_s} >= n_r) || ({1'b0, edge_b_s} >= n_r);
        // Self-loops are silently dropped; duplicates only ever lower the weight
        edge_wr_s   = edge_hs_s && !edge_bad_s && (edge_a_s != edge_b_s) &&
                      (!adj_vld_r[edge_a_s][edge_b_s] || (edge_w_s < adj_wt_r[edge_a_s][edge_b_s]));
        start_bad_s = (num_nodes == NCNT_ZERO_C) || (num_nodes > NMAX_C) ||
                      ({1'b0, src} >= num_nodes);

        // Strict less-than keeps the earliest index on ties
        sel_take_s  = ({1'b0, idx_r} < n_r) && !visited_r[idx_r] &&
                      (!found_r || (dist_r[idx_r] < best_dist_r));
        if (sel_take_s) begin
            sel_node_s = idx_r;
            sel_dist_s = dist_r[idx_r];
        end else begin
            sel_node_s = best_node_r;
            sel_dist_s = best_dist_r;
        end
        sel_found_s  = found_r | sel_take_s;
        scan_end_s   = (idx_r == IDX_LAST_C);
        sel_commit_s = (state_r == S_SELECT) && scan_end_s && sel_found_s && (sel_dist_s != INF_C);

        // One extra bit so a saturating sum can never wrap below INF
        relax_sum_s = {1'b0, dist_r[u_r]} + {{(DIST_W+1-WT_W){1'b0}}, adj_wt_r[u_r][idx_r]};
        relax_upd_s = (state_r == S_RELAX) && adj_vld_r[u_r][idx_r] && !visited_r[idx_r] &&
                      (relax_sum_s < {1'b0, dist_r[idx_r]}) && (relax_sum_s < {1'b0, INF_C});

        out_hs_s   = dist_valid_r & dist_ready;
        idx_next_s = idx_r + IDX_ONE_C;
    end

    // Adjacency matrix: wiped in CLEAR, written symmetrically on accepted edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < N_C; a++) begin
                adj_vld_r[a] <= {N_C{1'b0}};
                for (int b = 0; b < N_C; b++) begin
                    adj_wt_r[a][b] <= {WT_W{1'b0}};
                end
            end
        end else if (state_r == S_CLEAR) begin
            for (int a = 0; a < N_C; a++) begin
                adj_vld_r[a] <= {N_C{1'b0}};
            end
        end else if (edge_wr_s) begin
            adj_vld_r[edge_a_s][edge_b_s] <= 1'b1;
            adj_vld_r[edge_b_s][edge_a_s] <= 1'b1;
            adj_wt_r[edge_a_s][edge_b_s]  <= edge_w_s;
            adj_wt_r[edge_b_s][edge_a_s]  <= edge_w_s;
        end
    end

    // Distance and visited storage: initialised in CLEAR, updated by SELECT/RELAX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_C; k++) begin
                dist_r[k] <= DZERO_C;
            end
            visited_r <= {N_C{1'b0}};
        end else begin
            case (state_r)
                S_CLEAR: begin
                    for (int k = 0; k < N_C; k++) begin
                        dist_r[k] <= INF_C;
                    end
                    dist_r[src_r] <= DZERO_C;
                    visited_r     <= {N_C{1'b0}};
                end
                S_SELECT: begin
                    if (sel_commit_s) begin
                        visited_r[sel_node_s] <= 1'b1;
                    end
                end
                S_RELAX: begin
                    if (relax_upd_s) begin
                        dist_r[idx_r] <= relax_sum_s[DIST_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Job sequencing, scan counters and the registered stream/status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            n_r          <= NCNT_ZERO_C;
            src_r        <= IDX_ZERO_C;
            idx_r        <= IDX_ZERO_C;
            u_r          <= IDX_ZERO_C;
            best_node_r  <= IDX_ZERO_C;
            best_dist_r  <= DZERO_C;
            found_r      <= 1'b0;
            edge_ready_r <= 1'b0;
            dist_valid_r <= 1'b0;
            dist_node_r  <= IDX_ZERO_C;
            dist_value_r <= DZERO_C;
            dist_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        n_r   <= num_nodes;
                        src_r <= src;
                        if (start_bad_s) begin
                            error_r <= 1'b1;
                            done_r  <= 1'b1;
                        end else begin
                            error_r <= 1'b0;
                            busy_r  <= 1'b1;
                            state_r <= S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    edge_ready_r <= 1'b1;
                    state_r      <= S_LOAD;
                end
                S_LOAD: begin
                    if (edge_hs_s) begin
                        if (edge_bad_s) begin
                            error_r <= 1'b1;
                        end
                        if (edge_last) begin
                            edge_ready_r <= 1'b0;
                            idx_r        <= IDX_ZERO_C;
                            found_r      <= 1'b0;
                            state_r      <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    found_r     <= sel_found_s;
                    best_node_r <= sel_node_s;
                    best_dist_r <= sel_dist_s;
                    if (scan_end_s) begin
                        idx_r   <= IDX_ZERO_C;
                        found_r <= 1'b0;
                        if (sel_commit_s) begin
                            u_r     <= sel_node_s;
                            state_r <= S_RELAX;
                        end else begin
                            // Nothing reachable left: start streaming node 0
                            state_r      <= S_OUTPUT;
                            dist_valid_r <= 1'b1;
                            dist_node_r  <= IDX_ZERO_C;
                            dist_value_r <= dist_r[0];
                            dist_last_r  <= (n_r == NCNT_ONE_C);
                        end
                    end else begin
                        idx_r <= idx_next_s;
                    end
                end
                S_RELAX: begin
                    if (scan_end_s) begin
                        idx_r   <= IDX_ZERO_C;
                        found_r <= 1'b0;
                        state_r <= S_SELECT;
                    end else begin
                        idx_r <= idx_next_s;
                    end
                end
                S_OUTPUT: begin
                    if (out_hs_s) begin
                        if (dist_last_r) begin
                            dist_valid_r <= 1'b0;
                            dist_node_r  <= IDX_ZERO_C;
                            dist_value_r <= DZERO_C;
                            dist_last_r  <= 1'b0;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                            state_r      <= S_IDLE;
                        end else begin
                            idx_r        <= idx_next_s;
                            dist_node_r  <= idx_next_s;
                            dist_value_r <= dist_r[idx_next_s];
                            dist_last_r  <= ({1'b0, idx_next_s} == (n_r - NCNT_ONE_C));
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
